// File: rtl/mc14500_pkg.sv
// Shared constants and types for the MC14500 serial I/O controller.
package mc14500_pkg;

  localparam int unsigned SIO_TX0  = 0;
  localparam int unsigned SIO_GO   = 8;
  localparam int unsigned SIO_OUT1 = 9;
  localparam int unsigned SIO_OUT2 = 10;
  localparam int unsigned SIO_CLR  = 11;

  localparam int unsigned RD_BUSY = 8;
  localparam int unsigned RD_RXV  = 9;
  localparam int unsigned RD_OVR  = 10;

  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sio_state_t;

endpackage

// File: rtl/mc14500_sio_shifter.sv
// Frame datapath: outgoing data/stop bits, incoming data bits and the bit counter.
module mc14500_sio_shifter
  import mc14500_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic       sample,
  input  logic [7:0] txhold,
  input  logic       sdi,
  output logic       tx_next,
  output logic [7:0] rx_data,
  output logic [3:0] bitcnt
);

  // The start bit goes straight to sdo at load, so only data and stop bits are kept.
  logic [8:0] tx_shift;

  assign tx_next = tx_shift[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '1;
      rx_data  <= '0;
      bitcnt   <= '0;
    end else begin
      if (load) begin
        tx_shift <= {1'b1, txhold};
        bitcnt   <= '0;
      end else if (step) begin
        tx_shift <= {1'b1, tx_shift[8:1]};
        bitcnt   <= bitcnt + 4'd1;
      end
      if (sample) begin
        rx_data <= {sdi, rx_data[7:1]};
      end
    end
  end

endmodule

// File: rtl/mc14500_sio_ctrl.sv
// Serial link controller: maps 1-bit core I/O accesses onto tx/rx bytes and
// clocks out 10-bit frames (start, 8 data LSB first, stop).
//
// state | meaning
// IDLE  | no frame, sdo at mark, waiting for a trigger write
// LOW   | sclk low half of the current bit
// HIGH  | sclk high half of the current bit (sdi sampled on entry)
// DONE  | one cycle to hand the received byte to rxbuf
module mc14500_sio_ctrl
  import mc14500_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic              io_wdata,
  output logic              io_rdata,
  output logic              sclk,
  output logic              sdo,
  input  logic              sdi,
  output logic              out_1,
  output logic              out_2,
  output logic              busy
);

  localparam logic [7:0] DIV_MAX  = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  sio_state_t state;
  logic [7:0] divcnt;
  logic [7:0] txhold;
  logic [7:0] rxbuf;
  logic       rx_valid;
  logic       ovr;

  logic [7:0] rx_data;
  logic [3:0] bitcnt;
  logic       tx_next;

  logic div_tc;
  logic wr_tx, wr_go, wr_out1, wr_out2, wr_clr;
  logic start, step, sample;

  assign busy    = (state != ST_IDLE);
  assign div_tc  = (divcnt == 8'd0);

  assign wr_tx   = io_we && (io_addr < ADDR_W'(SIO_GO));
  assign wr_go   = io_we && io_wdata && (io_addr == ADDR_W'(SIO_GO));
  assign wr_out1 = io_we && (io_addr == ADDR_W'(SIO_OUT1));
  assign wr_out2 = io_we && (io_addr == ADDR_W'(SIO_OUT2));
  assign wr_clr  = io_we && io_wdata && (io_addr == ADDR_W'(SIO_CLR));

  assign start  = wr_go && (state == ST_IDLE);
  assign step   = (state == ST_HIGH) && div_tc && (bitcnt != LAST_BIT);
  assign sample = (state == ST_LOW) && div_tc && (bitcnt != 4'd0) && (bitcnt != LAST_BIT);

  mc14500_sio_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .step    (step),
    .sample  (sample),
    .txhold  (txhold),
    .sdi     (sdi),
    .tx_next (tx_next),
    .rx_data (rx_data),
    .bitcnt  (bitcnt)
  );

  // Divider is a down-counter reloaded at every half-bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      divcnt <= '0;
      sclk   <= 1'b0;
      sdo    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_LOW;
            divcnt <= DIV_MAX;
            sclk   <= 1'b0;
            sdo    <= 1'b0;
          end
        end
        ST_LOW: begin
          if (div_tc) begin
            state  <= ST_HIGH;
            divcnt <= DIV_MAX;
            sclk   <= 1'b1;
          end else begin
            divcnt <= divcnt - 8'd1;
          end
        end
        ST_HIGH: begin
          if (div_tc) begin
            divcnt <= DIV_MAX;
            sclk   <= 1'b0;
            if (bitcnt == LAST_BIT) begin
              state <= ST_DONE;
            end else begin
              state <= ST_LOW;
              sdo   <= tx_next;
            end
          end else begin
            divcnt <= divcnt - 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          sdo   <= 1'b1;
        end
      endcase
    end
  end

  // Later assignments win: frame completion and overrun flags override a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txhold   <= '0;
      rxbuf    <= '0;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
      out_1    <= 1'b0;
      out_2    <= 1'b0;
    end else begin
      if (wr_tx) begin
        txhold[io_addr[2:0]] <= io_wdata;
      end
      if (wr_out1) begin
        out_1 <= io_wdata;
      end
      if (wr_out2) begin
        out_2 <= io_wdata;
      end
      if (wr_clr) begin
        ovr      <= 1'b0;
        rx_valid <= 1'b0;
      end
      if (wr_go && busy) begin
        ovr <= 1'b1;
      end
      if (state == ST_DONE) begin
        rxbuf    <= rx_data;
        rx_valid <= 1'b1;
        if (rx_valid) begin
          ovr <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    io_rdata = 1'b0;
    if (io_addr < ADDR_W'(SIO_GO)) begin
      io_rdata = rxbuf[io_addr[2:0]];
    end else if (io_addr == ADDR_W'(RD_BUSY)) begin
      io_rdata = busy;
    end else if (io_addr == ADDR_W'(RD_RXV)) begin
      io_rdata = rx_valid;
    end else if (io_addr == ADDR_W'(RD_OVR)) begin
      io_rdata = ovr;
    end
  end

endmodule

// File: tb/tb_mc14500_sio_ctrl.sv
// Directed bench: register-map vector table plus frame sequences at CLK_DIV=4 and 1.
module tb_mc14500_sio_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, we, wdata, rdata, sclk, sdo, sdi, out_1, out_2, busy;
  logic [1:0][3:0] addr;

  // sdi loops back from sdo so every frame is also received.
  assign sdi = sdo;

  mc14500_sio_ctrl #(.CLK_DIV(4), .ADDR_W(4)) u_div4 (
    .clk(clk), .rst(rst[0]), .io_we(we[0]), .io_addr(addr[0]), .io_wdata(wdata[0]),
    .io_rdata(rdata[0]), .sclk(sclk[0]), .sdo(sdo[0]), .sdi(sdi[0]),
    .out_1(out_1[0]), .out_2(out_2[0]), .busy(busy[0])
  );

  mc14500_sio_ctrl #(.CLK_DIV(1), .ADDR_W(4)) u_div1 (
    .clk(clk), .rst(rst[1]), .io_we(we[1]), .io_addr(addr[1]), .io_wdata(wdata[1]),
    .io_rdata(rdata[1]), .sclk(sclk[1]), .sdo(sdo[1]), .sdi(sdi[1]),
    .out_1(out_1[1]), .out_2(out_2[1]), .busy(busy[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Line monitor: busy cycles, frames, sclk rises, rise spacing, sdo at each rise.
  int         cyc = 0;
  int         busy_cyc[2]  = '{0, 0};
  int         frames[2]    = '{0, 0};
  int         rises[2]     = '{0, 0};
  int         per_bad[2]   = '{0, 0};
  int         frise[2]     = '{0, 0};
  int         last_rise[2] = '{0, 0};
  logic [9:0] cap[2]       = '{10'd0, 10'd0};
  logic [1:0] busy_q = 2'b00;
  logic [1:0] sclk_q = 2'b00;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= busy;
    sclk_q <= sclk;
    for (int d = 0; d < 2; d++) begin
      if (busy[d]) busy_cyc[d] <= busy_cyc[d] + 1;
      if (busy[d] && !busy_q[d]) begin
        frames[d] <= frames[d] + 1;
        frise[d]  <= 0;
      end else if (sclk[d] && !sclk_q[d]) begin
        rises[d]     <= rises[d] + 1;
        frise[d]     <= frise[d] + 1;
        last_rise[d] <= cyc;
        cap[d]       <= {sdo[d], cap[d][9:1]};
        if (frise[d] != 0 && (cyc - last_rise[d]) != ((d == 0) ? 8 : 2))
          per_bad[d] <= per_bad[d] + 1;
      end
    end
  end

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic       wd;
    logic       rd;
    logic       o1;
    logic       o2;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wr(input int d, input logic [3:0] a, input logic v);
    @(negedge clk);
    we[d]    = 1'b1;
    addr[d]  = a;
    wdata[d] = v;
    @(negedge clk);
    we[d]    = 1'b0;
  endtask

  task automatic rd(input int d, input logic [3:0] a, output logic v);
    addr[d] = a;
    #1;
    v = rdata[d];
  endtask

  task automatic wr_byte(input int d, input logic [7:0] b);
    for (int i = 0; i < 8; i++) wr(d, 4'(i), b[i]);
  endtask

  task automatic rd_byte(input int d, output logic [7:0] b);
    logic v;
    for (int i = 0; i < 8; i++) begin
      rd(d, 4'(i), v);
      b[i] = v;
    end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (busy[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy[d]), 32'd0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       v;
    logic [7:0] b;
    int b0, r0, f0, p0;

    rst = 2'b11; we = 2'b00; wdata = 2'b00; addr = '0;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    #1;

    for (int d = 0; d < 2; d++) begin
      chk("rst_sclk", 32'(sclk[d]), 32'd0);
      chk("rst_sdo", 32'(sdo[d]), 32'd1);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_out", 32'({out_1[d], out_2[d]}), 32'd0);
    end

    tbl[0]  = '{1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'd9,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'd10, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].we) wr(0, tbl[i].addr, tbl[i].wd);
      rd(0, tbl[i].addr, v);
      chk($sformatf("vec%0d_rdata", i), 32'(v), 32'(tbl[i].rd));
      chk($sformatf("vec%0d_out1", i), 32'(out_1[0]), 32'(tbl[i].o1));
      chk($sformatf("vec%0d_out2", i), 32'(out_2[0]), 32'(tbl[i].o2));
    end

    // 0x31 frame at CLK_DIV=4
    wr_byte(0, 8'h31);
    settle();
    b0 = busy_cyc[0]; r0 = rises[0]; p0 = per_bad[0];
    wr(0, 4'd8, 1'b1);
    chk("t1_busy_set", 32'(busy[0]), 32'd1);
    wait_idle(0, 400);
    settle();
    chk("t1_busy_cycles", 32'(busy_cyc[0] - b0), 32'd81);
    chk("t1_rises", 32'(rises[0] - r0), 32'd10);
    chk("t1_period", 32'(per_bad[0] - p0), 32'd0);
    chk("t1_frame", 32'(cap[0]), 32'(frame_of(8'h31)));
    chk("t1_sdo_idle", 32'(sdo[0]), 32'd1);
    chk("t1_sclk_idle", 32'(sclk[0]), 32'd0);

    // loopback receive of 0x41
    wr(0, 4'd11, 1'b1);
    wr_byte(0, 8'h41);
    wr(0, 4'd8, 1'b1);
    wait_idle(0, 400);
    settle();
    rd_byte(0, b);
    chk("t2_rxbuf", 32'(b), 32'h41);
    rd(0, 4'd9, v);
    chk("t2_rx_valid", 32'(v), 32'd1);
    rd(0, 4'd10, v);
    chk("t2_ovr", 32'(v), 32'd0);

    // trigger while busy
    wr(0, 4'd11, 1'b1);
    wr_byte(0, 8'h5A);
    settle();
    f0 = frames[0]; r0 = rises[0];
    wr(0, 4'd8, 1'b1);
    repeat (8) @(negedge clk);
    wr(0, 4'd8, 1'b1);
    rd(0, 4'd10, v);
    chk("t3_ovr_set", 32'(v), 32'd1);
    wait_idle(0, 400);
    settle();
    chk("t3_frames", 32'(frames[0] - f0), 32'd1);
    chk("t3_rises", 32'(rises[0] - r0), 32'd10);
    chk("t3_frame", 32'(cap[0]), 32'(frame_of(8'h5A)));
    wr(0, 4'd11, 1'b1);
    rd(0, 4'd10, v);
    chk("t3_ovr_clr", 32'(v), 32'd0);
    rd(0, 4'd9, v);
    chk("t3_rxv_clr", 32'(v), 32'd0);

    // txhold rewritten mid-frame
    wr_byte(0, 8'h2A);
    wr(0, 4'd8, 1'b1);
    repeat (20) @(negedge clk);
    wr_byte(0, 8'hFF);
    wait_idle(0, 400);
    settle();
    chk("t4_frame_a", 32'(cap[0]), 32'(frame_of(8'h2A)));
    rd_byte(0, b);
    chk("t4_rxbuf_a", 32'(b), 32'h2A);
    wr(0, 4'd8, 1'b1);
    wait_idle(0, 400);
    settle();
    chk("t4_frame_b", 32'(cap[0]), 32'(frame_of(8'hFF)));
    rd_byte(0, b);
    chk("t4_rxbuf_b", 32'(b), 32'hFF);
    rd(0, 4'd10, v);
    chk("t4_rx_overrun", 32'(v), 32'd1);

    // async reset in the high half of bit 5 (data bit 4 of 0x2C is 0)
    wr(0, 4'd11, 1'b1);
    wr(0, 4'd9, 1'b1);
    wr_byte(0, 8'h2C);
    wr(0, 4'd8, 1'b1);
    wait_idle(0, 400);
    wr(0, 4'd8, 1'b1);
    repeat (45) @(negedge clk);
    chk("t5_pre_sclk", 32'(sclk[0]), 32'd1);
    chk("t5_pre_sdo", 32'(sdo[0]), 32'd0);
    rd(0, 4'd9, v);
    chk("t5_pre_rxv", 32'(v), 32'd1);
    #1;
    rst[0] = 1'b1;
    #1;
    chk("t5_sclk", 32'(sclk[0]), 32'd0);
    chk("t5_sdo", 32'(sdo[0]), 32'd1);
    chk("t5_busy", 32'(busy[0]), 32'd0);
    chk("t5_out1", 32'(out_1[0]), 32'd0);
    rd(0, 4'd9, v);
    chk("t5_rxv", 32'(v), 32'd0);
    rd_byte(0, b);
    chk("t5_rxbuf", 32'(b), 32'h00);
    @(negedge clk);
    rst[0] = 1'b0;
    wr_byte(0, 8'hC6);
    wr(0, 4'd8, 1'b1);
    wait_idle(0, 400);
    settle();
    chk("t5_frame", 32'(cap[0]), 32'(frame_of(8'hC6)));
    rd_byte(0, b);
    chk("t5_rxbuf_after", 32'(b), 32'hC6);

    // CLK_DIV=1 frame with output writes during it
    wr_byte(1, 8'h0D);
    settle();
    b0 = busy_cyc[1]; r0 = rises[1]; p0 = per_bad[1];
    wr(1, 4'd8, 1'b1);
    wr(1, 4'd9, 1'b1);
    wr(1, 4'd10, 1'b1);
    wait_idle(1, 100);
    settle();
    chk("t6_busy_cycles", 32'(busy_cyc[1] - b0), 32'd21);
    chk("t6_rises", 32'(rises[1] - r0), 32'd10);
    chk("t6_period", 32'(per_bad[1] - p0), 32'd0);
    chk("t6_frame", 32'(cap[1]), 32'(frame_of(8'h0D)));
    chk("t6_out", 32'({out_1[1], out_2[1]}), 32'd3);
    rd_byte(1, b);
    chk("t6_rxbuf", 32'(b), 32'h0D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
